pipeline_ctrl: RTL
==================

# pipeline_ctrl

Hazard, stall and flush controller for the five-stage core pipeline (fetch, decode, execute, memory, writeback). It owns the valid bit of each inter-stage register and drives that register's load enable. It detects load-use hazards and squashes wrong-path instructions on a taken jump or branch. It runs the memory-stage bus handshake FSM and counts retired instructions. Operand forwarding and datapath registers live outside this block.

## Interface

- XLEN, 32, data/address width (redirect target, retire counter)
- clk  in  1  core clock
- rst_n  in  1  asynchronous, active-low reset
- if_valid_i  in  1  fetch presents an instruction
- if_ready_o  out  1  fetch may advance (decode register loads this cycle)
- de_rs1_addr_i, de_rs2_addr_i  in  5 each  decode source registers
- de_rs1_used_i, de_rs2_used_i  in  1 each  source actually read
- ex_rd_addr_i  in  5  execute-stage destination
- ex_mm_re_i  in  1  execute-stage instruction is a load
- ex_redirect_i  in  1  execute resolved a taken jump/branch
- ex_target_i  in  XLEN  resolved target
- mm_req_i  in  1  memory-stage instruction has mm_re or mm_we
- mm_ack_i  in  1  bus completes access this cycle
- mm_stb_o  out  1  bus strobe
- de_en_o, ex_en_o, mm_en_o, wb_en_o  out  1 each  stage-register load enables
- de_valid_o, ex_valid_o, mm_valid_o, wb_valid_o  out  1 each  stage-register valid bits
- pc_redirect_o  out  1  fetch must load pc_target_o
- pc_target_o  out  XLEN  redirect target (= ex_target_i)
- retired_o  out  XLEN  retired-instruction count

## Operation

- Memory FSM, states MM_IDLE and MM_WAIT.
  - mm_stb_o = mm_valid & mm_req_i, in either state.
  - MM_IDLE goes to MM_WAIT on mm_stb_o & !mm_ack_i.
  - MM_WAIT goes to MM_IDLE on mm_ack_i.
  - mem_stall = mm_stb_o & !mm_ack_i.
- redirect = ex_valid & ex_redirect_i.
- lu_hazard = ex_valid & ex_mm_re_i & !ex_redirect_i & de_valid & ex_rd_addr_i≠0 & ((de_rs1_used_i & rs1==rd) | (de_rs2_used_i & rs2==rd)).
- Priority: mem_stall > redirect > lu_hazard > normal.
- mem_stall:
  - de_en, ex_en, mm_en, if_ready = 0; all upstream state held.
  - wb_en = 1, wb_valid ← 0 (bubble); this prevents a double writeback.
  - pc_redirect_o = 0, even if redirect is true; the redirect is taken later, once the stall clears.
- redirect:
  - All enables = 1, if_ready = 1.
  - de_valid ← 0 and ex_valid ← 0 (wrong path squashed).
  - mm_valid ← ex_valid, so the jump itself proceeds and may write rd.
  - wb_valid ← mm_valid.
  - pc_redirect_o = 1, pc_target_o = ex_target_i.
- lu_hazard:
  - de_en = 0, if_ready = 0 (decode and fetch hold).
  - ex_en = 1, ex_valid ← 0 (bubble).
  - mm and wb advance normally.
- normal:
  - All enables = 1, if_ready = 1.
  - de_valid ← if_valid_i, ex_valid ← de_valid, mm_valid ← ex_valid, wb_valid ← mm_valid.
- retired_o increments by 1 every cycle wb_valid = 1; it wraps modulo 2^XLEN.
- Enables, if_ready_o, mm_stb_o and pc_redirect_o are combinational from current state and inputs. Valid bits, FSM state and counter are registered.

## Timing

- Reset, asynchronous and immediate:
  - all valid bits 0, FSM MM_IDLE, retired_o 0.
  - mm_stb_o 0, pc_redirect_o 0.
  - all enables 1 and if_ready_o 1, since no hazards exist.
- Reset asserted mid-access abandons the access; mm_stb_o drops with reset.
- Load-use costs exactly 1 bubble cycle. The next cycle the load sits in memory and the hazard clears.
- Redirect penalty is 2 cycles (two squashed slots). pc_redirect_o is a single-cycle pulse per redirect instruction. Under mem_stall it is deferred, not lost.
- Memory access of N wait cycles (ack N cycles after first strobe) stalls upstream N cycles and inserts N wb bubbles. A same-cycle ack means zero stall.
- mm_stb_o stays high continuously from first assertion until ack.

## Test plan

- Reset: hold rst_n=0 with random inputs -> all valid 0, retired_o=0, mm_stb_o=0. After release with if_valid_i=1 each cycle, wb_valid_o first becomes 1 in cycle 4.
- Load-use: load to x5 in ex, decode reads rs1=x5 with used=1 -> one cycle of de_en_o=0, if_ready_o=0, ex_valid←0, then flow resumes. Repeat with rd=x0 -> no stall.
- Redirect: ex_redirect_i=1, ex_target_i=0x0000_0100 -> pc_redirect_o pulse of 1 cycle with target 0x100. Next cycle de_valid_o=0 and ex_valid_o=0, and mm_valid_o=1 carries the jump.
- Memory wait: store in mm, mm_ack_i arrives 3 cycles after strobe -> mm_stb_o high 4 cycles, upstream frozen 3 cycles, 3 wb bubbles, retired_o unchanged during the wait.
- Simultaneous: mem_stall with ex_redirect_i=1 -> no pc_redirect_o until the ack cycle, then a single pulse. Also a load-use hazard with redirect in the same cycle -> redirect wins.
- Counter wrap: preload through 2^32-1 retirements (or force) -> next retirement gives retired_o=0.

Source files
------------

// File: rtl/pipeline_ctrl_if.sv
// Handshake/control bundle between the core pipeline and its hazard/stall/flush controller.
// The controller attaches through the slave modport; the core side uses master.
interface pipeline_ctrl_if #(parameter int XLEN = 32);
  logic            if_valid_i;
  logic            if_ready_o;
  logic [4:0]      de_rs1_addr_i;
  logic [4:0]      de_rs2_addr_i;
  logic            de_rs1_used_i;
  logic            de_rs2_used_i;
  logic [4:0]      ex_rd_addr_i;
  logic            ex_mm_re_i;
  logic            ex_redirect_i;
  logic [XLEN-1:0] ex_target_i;
  logic            mm_req_i;
  logic            mm_ack_i;
  logic            mm_stb_o;
  logic            de_en_o;
  logic            ex_en_o;
  logic            mm_en_o;
  logic            wb_en_o;
  logic            de_valid_o;
  logic            ex_valid_o;
  logic            mm_valid_o;
  logic            wb_valid_o;
  logic            pc_redirect_o;
  logic [XLEN-1:0] pc_target_o;
  logic [XLEN-1:0] retired_o;

  modport slave (
    input  if_valid_i, de_rs1_addr_i, de_rs2_addr_i, de_rs1_used_i, de_rs2_used_i,
           ex_rd_addr_i, ex_mm_re_i, ex_redirect_i, ex_target_i, mm_req_i, mm_ack_i,
    output if_ready_o, mm_stb_o, de_en_o, ex_en_o, mm_en_o, wb_en_o,
           de_valid_o, ex_valid_o, mm_valid_o, wb_valid_o,
           pc_redirect_o, pc_target_o, retired_o
  );

  modport master (
    output if_valid_i, de_rs1_addr_i, de_rs2_addr_i, de_rs1_used_i, de_rs2_used_i,
           ex_rd_addr_i, ex_mm_re_i, ex_redirect_i, ex_target_i, mm_req_i, mm_ack_i,
    input  if_ready_o, mm_stb_o, de_en_o, ex_en_o, mm_en_o, wb_en_o,
           de_valid_o, ex_valid_o, mm_valid_o, wb_valid_o,
           pc_redirect_o, pc_target_o, retired_o
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline controller: stage valid bits and load enables, load-use bubbles,
// redirect squash, memory-stage bus handshake and retired-instruction counter.
module pipeline_ctrl #(
    parameter int XLEN = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    pipeline_ctrl_if.slave bus
);

    typedef enum logic {MM_IDLE, MM_WAIT} mm_state_t;

    mm_state_t       mm_state, mm_state_nxt;
    logic            de_valid, ex_valid, mm_valid, wb_valid;
    logic [XLEN-1:0] retired;
    logic            mm_stb, mem_stall, redirect, lu_hazard, rs1_hit, rs2_hit;

    assign mm_stb    = mm_valid & bus.mm_req_i;
    assign mem_stall = mm_stb & ~bus.mm_ack_i;
    assign redirect  = ex_valid & bus.ex_redirect_i;

    assign rs1_hit   = bus.de_rs1_used_i & (bus.de_rs1_addr_i == bus.ex_rd_addr_i);
    assign rs2_hit   = bus.de_rs2_used_i & (bus.de_rs2_addr_i == bus.ex_rd_addr_i);
    // A redirecting instruction squashes decode anyway, so it never raises a load-use bubble.
    assign lu_hazard = ex_valid & bus.ex_mm_re_i & ~bus.ex_redirect_i & de_valid &
                       (bus.ex_rd_addr_i != 5'd0) & (rs1_hit | rs2_hit);

    always_comb begin
        mm_state_nxt = mm_state;
        case (mm_state)
            MM_IDLE: if (mm_stb && !bus.mm_ack_i) mm_state_nxt = MM_WAIT;
            MM_WAIT: if (bus.mm_ack_i)            mm_state_nxt = MM_IDLE;
            default:                              mm_state_nxt = MM_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mm_state <= MM_IDLE;
        else        mm_state <= mm_state_nxt;
    end

    // Redirect is suppressed while memory stalls; ex holds the jump, so it fires once the stall clears.
    assign bus.de_en_o       = ~mem_stall & ~lu_hazard;
    assign bus.if_ready_o    = ~mem_stall & ~lu_hazard;
    assign bus.ex_en_o       = ~mem_stall;
    assign bus.mm_en_o       = ~mem_stall;
    assign bus.wb_en_o       = 1'b1;
    assign bus.mm_stb_o      = mm_stb;
    assign bus.pc_redirect_o = redirect & ~mem_stall;
    assign bus.pc_target_o   = bus.ex_target_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de_valid <= 1'b0;
            ex_valid <= 1'b0;
            mm_valid <= 1'b0;
            wb_valid <= 1'b0;
        end else if (mem_stall) begin
            wb_valid <= 1'b0;
        end else begin
            wb_valid <= mm_valid;
            mm_valid <= ex_valid;
            ex_valid <= (redirect | lu_hazard) ? 1'b0 : de_valid;
            if (redirect)       de_valid <= 1'b0;
            else if (!lu_hazard) de_valid <= bus.if_valid_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        retired <= '0;
        else if (wb_valid) retired <= retired + {{(XLEN-1){1'b0}}, 1'b1};
    end

    assign bus.de_valid_o = de_valid;
    assign bus.ex_valid_o = ex_valid;
    assign bus.mm_valid_o = mm_valid;
    assign bus.wb_valid_o = wb_valid;
    assign bus.retired_o  = retired;

endmodule
